evt_group_scheduler: RTL and testbench

//  Top-level event scheduler of the 2-level pixel arbiter hierarchy; 32x32 array, 8x8 groups of 4x4.

---
 rtl/evt_group_scheduler_pkg.sv | 32 +++
 rtl/evt_group_scheduler_rr_pick.sv | 39 +++
 rtl/evt_group_scheduler.sv | 132 +++++++++++++
 tb/tb_evt_group_scheduler.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/evt_group_scheduler_pkg.sv
// Shared types and sizes for the top-level event scheduler of the 2-level
// pixel arbiter hierarchy (32x32 pixels, 8x8 groups of 4x4 pixels).
// Holds the array geometry, the emitted packet layout and the scheduler
// state encoding.
package evt_group_scheduler_pkg;

  localparam int Lvl_ROWS    = 8;   // groups per row at the higher level
  localparam int Lvl_COLS    = 8;   // groups per column at the higher level
  localparam int Lvl_ADD     = 3;   // group row/col index width
  localparam int Lvl0_ADD    = 2;   // in-group pixel row/col address width
  localparam int NUM_GROUPS0 = Lvl_ROWS * Lvl_COLS;
  localparam int SIZE        = 32;  // timestamp width
  localparam int ROW_ADD     = Lvl_ADD + Lvl0_ADD;
  localparam int COL_ADD     = Lvl_ADD + Lvl0_ADD;
  localparam int WIDTH       = SIZE + ROW_ADD + COL_ADD + 1;
  localparam int GRP_IDX_W   = $clog2(NUM_GROUPS0);

  // Emitted event: {timestamp, full row, full col, polarity}.
  typedef struct packed {
    logic [SIZE-1:0]    ts;
    logic [ROW_ADD-1:0] row;
    logic [COL_ADD-1:0] col;
    logic               pol;
  } evt_pkt_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    SETTLE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/evt_group_scheduler_rr_pick.sv
// Combinational round-robin picker.
// Finds the first set bit of req_i starting at ptr_i and walking upwards,
// wrapping from N-1 back to 0.
// Ports:
//   req_i  in  N      request vector
//   ptr_i  in  IDX_W  highest-priority index this cycle
//   gnt_o  out N      one-hot grant (all-zero when nothing requests)
//   idx_o  out IDX_W  winner index (0 when nothing requests)
//   any_o  out 1      at least one request is set
module evt_group_scheduler_rr_pick #(
  parameter int N     = 64,
  parameter int IDX_W = 6
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W:0] cand;

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      // One extra bit so the wrap works for non-power-of-two N as well.
      cand = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (!any_o && req_i[cand[IDX_W-1:0]]) begin
        any_o = 1'b1;
        idx_o = cand[IDX_W-1:0];
      end
    end
    gnt_o = any_o ? ({{(N-1){1'b0}}, 1'b1} << idx_o) : '0;
  end

endmodule

// File: rtl/evt_group_scheduler.sv
// Top-level event scheduler: shares one output event port between the
// lower-level group arbiters with round-robin, acks the winning group,
// stamps the event with a free-running timestamp and queues it in a
// 2-entry output FIFO.
// Ports:
//   clk_i, reset_i       clock, synchronous active-high reset
//   en_i                 scheduler and timestamp enable
//   grp_req_i            per-group pending-event flag
//   grp_row_i/grp_col_i  per-group in-group row/col address of the event
//   grp_pol_i            per-group event polarity (1=ON)
//   grp_ack_o            one-hot, 1-cycle pulse: that group's event was taken
//   evt_valid_o/evt_ready_i/evt_data_o  output event stream
//   ts_o                 current timestamp counter
//   dbg_state_o          scheduler FSM state
//
// Output handshake: evt_data_o is a packet whenever evt_valid_o=1; the head
// is consumed on a clock edge where evt_valid_o & evt_ready_i, and it holds
// unchanged while evt_valid_o & ~evt_ready_i. evt_valid_o never depends
// combinationally on evt_ready_i.
module evt_group_scheduler
  import evt_group_scheduler_pkg::*;
(
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 en_i,
  input  logic [NUM_GROUPS0-1:0]               grp_req_i,
  input  logic [NUM_GROUPS0-1:0][Lvl0_ADD-1:0] grp_row_i,
  input  logic [NUM_GROUPS0-1:0][Lvl0_ADD-1:0] grp_col_i,
  input  logic [NUM_GROUPS0-1:0]               grp_pol_i,
  output logic [NUM_GROUPS0-1:0]               grp_ack_o,
  output logic                                 evt_valid_o,
  input  logic                                 evt_ready_i,
  output logic [WIDTH-1:0]                     evt_data_o,
  output logic [SIZE-1:0]                      ts_o,
  output sched_state_t                         dbg_state_o
);

  localparam int FIFO_DEPTH = 2;

  sched_state_t         state_q, state_d;
  logic [GRP_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SIZE-1:0]      ts_q, ts_d;
  evt_pkt_t             mem_q [FIFO_DEPTH];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           cnt_q, cnt_d;

  logic [NUM_GROUPS0-1:0] pick_gnt;
  logic [GRP_IDX_W-1:0]   pick_idx;
  logic                   pick_any;
  logic                   push, pop;
  evt_pkt_t               new_pkt;

  evt_group_scheduler_rr_pick #(
    .N     (NUM_GROUPS0),
    .IDX_W (GRP_IDX_W)
  ) u_rr_pick (
    .req_i (grp_req_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // A request that vanished between IDLE and GRANT produces no write.
  assign push = (state_q == GRANT) && pick_any;
  assign pop  = (cnt_q != 2'd0) && evt_ready_i;

  // Group index splits into grp_row = idx / Lvl_COLS, grp_col = idx % Lvl_COLS.
  always_comb begin
    new_pkt     = '0;
    new_pkt.ts  = ts_q;
    new_pkt.row = {Lvl_ADD'(pick_idx / GRP_IDX_W'(Lvl_COLS)), grp_row_i[pick_idx]};
    new_pkt.col = {Lvl_ADD'(pick_idx % GRP_IDX_W'(Lvl_COLS)), grp_col_i[pick_idx]};
    new_pkt.pol = grp_pol_i[pick_idx];
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        // Full-FIFO check here is what keeps the GRANT write from overflowing.
        if (en_i && pick_any && (cnt_q != 2'(FIFO_DEPTH))) state_d = GRANT;
      end
      GRANT: begin
        if (pick_any) begin
          rr_ptr_d = (pick_idx == GRP_IDX_W'(NUM_GROUPS0-1)) ? '0 : pick_idx + 1'b1;
          state_d  = SETTLE;
        end else begin
          state_d  = IDLE;
        end
      end
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ts_d     = en_i ? ts_q + 1'b1 : ts_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      ts_q     <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      ts_q     <= ts_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) mem_q[wr_ptr_q] <= new_pkt;
    end
  end

  assign grp_ack_o   = push ? pick_gnt : '0;
  assign evt_valid_o = (cnt_q != 2'd0);
  assign evt_data_o  = mem_q[rd_ptr_q];
  assign ts_o        = ts_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_evt_group_scheduler.sv
module tb_evt_group_scheduler;
  import evt_group_scheduler_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                                 reset_i;
  logic                                 en_i;
  logic [NUM_GROUPS0-1:0]               grp_req;
  logic [NUM_GROUPS0-1:0][Lvl0_ADD-1:0] grp_row;
  logic [NUM_GROUPS0-1:0][Lvl0_ADD-1:0] grp_col;
  logic [NUM_GROUPS0-1:0]               grp_pol;
  logic [NUM_GROUPS0-1:0]               grp_ack;
  logic                                 evt_valid;
  logic                                 evt_ready;
  logic [WIDTH-1:0]                     evt_data;
  logic [SIZE-1:0]                      ts;
  sched_state_t                         dbg_state;

  evt_group_scheduler dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .en_i        (en_i),
    .grp_req_i   (grp_req),
    .grp_row_i   (grp_row),
    .grp_col_i   (grp_col),
    .grp_pol_i   (grp_pol),
    .grp_ack_o   (grp_ack),
    .evt_valid_o (evt_valid),
    .evt_ready_i (evt_ready),
    .evt_data_o  (evt_data),
    .ts_o        (ts),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  // Reference timestamp: counts cycles with en_i=1, cleared by reset.
  logic [SIZE-1:0] mdl_ts = '0;
  always @(posedge clk) begin
    if (reset_i) mdl_ts <= '0;
    else if (en_i) mdl_ts <= mdl_ts + 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] mk_pkt(input logic [SIZE-1:0] t, input int g);
    logic [5:0] gi;
    gi = 6'(g);
    return {t, gi[5:3], grp_row[g], gi[2:0], grp_col[g], grp_pol[g]};
  endfunction

  // Every accepted head must be the oldest outstanding expected packet.
  always @(negedge clk) begin
    if (!reset_i && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) check("pop_unexpected", 64'(exp_q.size()), 64'd1);
      else check("pop_data", 64'(evt_data), 64'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    exp_q.delete();
  endtask

  // Wait (bounded) for the next ack, check it, then check it lasted one cycle.
  task automatic wait_ack(input int g, input string tag, input bit clr, input bit drop_en);
    int n = 0;
    while (grp_ack == '0 && n < 30) begin
      tick();
      n++;
    end
    check({tag, "_ack"}, 64'(grp_ack), 64'd1 << g);
    if (grp_ack != '0) exp_q.push_back(mk_pkt(mdl_ts, g));
    if (drop_en) en_i = 1'b0;
    tick();
    check({tag, "_ack_pulse"}, 64'(grp_ack), 64'd0);
    if (clr) grp_req[g] = 1'b0;
  endtask

  task automatic drain(input string tag);
    evt_ready = 1'b1;
    repeat (8) tick();
    check({tag, "_drained_q"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_drained_valid"}, 64'(evt_valid), 64'd0);
  endtask

  task automatic count_idle_acks(input int cycles, output int acks);
    acks = 0;
    repeat (cycles) begin
      tick();
      if (grp_ack != '0) acks++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acks;
    logic [SIZE-1:0] t_frz;

    reset_i   = 1'b1;
    en_i      = 1'b0;
    evt_ready = 1'b0;
    grp_req   = '1;
    for (int g = 0; g < NUM_GROUPS0; g++) begin
      grp_row[g] = 2'(g);
      grp_col[g] = 2'(g >> 1);
      grp_pol[g] = g[0];
    end
    grp_row[9] = 2'd2;
    grp_col[9] = 2'd3;
    grp_pol[9] = 1'b1;

    // 1. reset held 3 cycles with every group requesting
    repeat (3) begin
      tick();
      check("t1_rst_ack", 64'(grp_ack), 64'd0);
    end
    check("t1_valid", 64'(evt_valid), 64'd0);
    check("t1_ts", 64'(ts), 64'd0);
    check("t1_data", 64'(evt_data), 64'd0);
    check("t1_state", 64'(dbg_state), 64'(IDLE));
    grp_req = '0;
    reset_i = 1'b0;

    // 2. single event from group 9 stamped with ts=5
    en_i = 1'b1;
    repeat (4) tick();
    check("t2_ts_idle", 64'(ts), 64'd4);
    grp_req[9] = 1'b1;
    tick();
    check("t2_state_grant", 64'(dbg_state), 64'(GRANT));
    check("t2_ack", 64'(grp_ack), 64'd1 << 9);
    check("t2_ts_grant", 64'(ts), 64'd5);
    exp_q.push_back({32'd5, 5'b00110, 5'b00111, 1'b1});
    tick();
    check("t2_state_settle", 64'(dbg_state), 64'(SETTLE));
    check("t2_ack_pulse", 64'(grp_ack), 64'd0);
    check("t2_valid", 64'(evt_valid), 64'd1);
    check("t2_data", 64'(evt_data), 64'({32'd5, 5'b00110, 5'b00111, 1'b1}));
    grp_req[9] = 1'b0;
    evt_ready  = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("t2_valid_after_pop", 64'(evt_valid), 64'd0);

    // 3. round-robin over groups 0, 5, 63 from a fresh pointer
    do_reset();
    en_i      = 1'b1;
    evt_ready = 1'b1;
    grp_req[0]  = 1'b1;
    grp_req[5]  = 1'b1;
    grp_req[63] = 1'b1;
    wait_ack(0,  "t3_a", 1'b0, 1'b0);
    wait_ack(5,  "t3_b", 1'b0, 1'b0);
    wait_ack(63, "t3_c", 1'b0, 1'b0);
    wait_ack(0,  "t3_wrap", 1'b0, 1'b0);
    grp_req = '0;
    drain("t3");

    // 4. backpressure: pointer now 1, groups 10,20,30,40 requesting
    evt_ready   = 1'b0;
    grp_req[10] = 1'b1;
    grp_req[20] = 1'b1;
    grp_req[30] = 1'b1;
    grp_req[40] = 1'b1;
    wait_ack(10, "t4_a", 1'b1, 1'b0);
    wait_ack(20, "t4_b", 1'b1, 1'b0);
    count_idle_acks(12, acks);
    check("t4_no_ack_full", 64'(acks), 64'd0);
    check("t4_valid_hold", 64'(evt_valid), 64'd1);
    check("t4_data_hold", 64'(evt_data), 64'(mk_pkt(exp_q[0][WIDTH-1:WIDTH-SIZE], 10)));
    evt_ready = 1'b1;
    wait_ack(30, "t4_c", 1'b1, 1'b0);
    wait_ack(40, "t4_d", 1'b1, 1'b0);
    drain("t4");

    // 5. en_i dropped in GRANT; pointer now 41, groups 50 and 55 requesting
    grp_req[50] = 1'b1;
    grp_req[55] = 1'b1;
    wait_ack(50, "t5_a", 1'b0, 1'b1);
    t_frz = mdl_ts;
    count_idle_acks(10, acks);
    check("t5_no_ack_disabled", 64'(acks), 64'd0);
    check("t5_ts_frozen", 64'(ts), 64'(t_frz));
    check("t5_state_idle", 64'(dbg_state), 64'(IDLE));
    check("t5_drained_while_off", 64'(evt_valid), 64'd0);
    en_i = 1'b1;
    wait_ack(55, "t5_resume", 1'b1, 1'b0);
    wait_ack(50, "t5_b", 1'b1, 1'b0);
    drain("t5");

    // 6. timestamp wrap: preload all-ones, next stamp is 0
    en_i = 1'b0;
    force dut.ts_q = 32'hFFFF_FFFF;
    #1;
    release dut.ts_q;
    mdl_ts = 32'hFFFF_FFFF;
    check("t6_ts_preload", 64'(ts), 64'hFFFF_FFFF);
    grp_req[33] = 1'b1;
    en_i        = 1'b1;
    tick();
    check("t6_ack", 64'(grp_ack), 64'd1 << 33);
    check("t6_ts_wrapped", 64'(ts), 64'd0);
    exp_q.push_back({32'd0, 3'd4, grp_row[33], 3'd1, grp_col[33], grp_pol[33]});
    tick();
    grp_req[33] = 1'b0;
    drain("t6");

    // 6b. reset with the FIFO full discards both entries
    evt_ready  = 1'b0;
    grp_req[1] = 1'b1;
    grp_req[2] = 1'b1;
    wait_ack(1, "t6b_a", 1'b1, 1'b0);
    wait_ack(2, "t6b_b", 1'b1, 1'b0);
    tick();
    check("t6b_full_valid", 64'(evt_valid), 64'd1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    exp_q.delete();
    check("t6b_valid_cleared", 64'(evt_valid), 64'd0);
    check("t6b_ack_cleared", 64'(grp_ack), 64'd0);
    check("t6b_ts_cleared", 64'(ts), 64'd0);
    tick();
    check("t6b_still_empty", 64'(evt_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
